// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bundle for ram_arbiter.
// master: requesters plus RAM (drive requests and ram_in); slave: the arbiter.
interface ram_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                            rdy_in;
  logic [NUM_PORTS-1:0]            req_in;
  logic [NUM_PORTS-1:0]            we_in;
  logic [NUM_PORTS-1:0]            sgn_in;
  logic [2*NUM_PORTS-1:0]          size_in;
  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr_in;
  logic [DATA_WIDTH*NUM_PORTS-1:0] wdata_in;
  logic [NUM_PORTS-1:0]            done_out;
  logic [DATA_WIDTH-1:0]           rdata_out;
  logic [7:0]                      ram_in;
  logic                            ram_rw_out;
  logic [ADDR_WIDTH-1:0]           ram_addr_out;
  logic [7:0]                      ram_data_out;

  modport master (
    output rdy_in, req_in, we_in, sgn_in, size_in, addr_in, wdata_in, ram_in,
    input  done_out, rdata_out, ram_rw_out, ram_addr_out, ram_data_out
  );

  modport slave (
    input  rdy_in, req_in, we_in, sgn_in, size_in, addr_in, wdata_in, ram_in,
    output done_out, rdata_out, ram_rw_out, ram_addr_out, ram_data_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// Multi-port byte-serial RAM controller: round-robin grant, serialises
// 1/2/4/8-byte requests onto an 8-bit synchronous RAM, assembles reads.
module ram_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          clk_in,
  input logic          rst_in,
  ram_arbiter_if.slave bus
);
  localparam int unsigned MAXB = DATA_WIDTH / 8;
  localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            n_q, n_d;
  logic                  we_q, we_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MAXB-1:0][7:0]  wdata_q, wdata_d;
  logic [MAXB-1:0][7:0]  rbuf_q, rbuf_d;
  logic [PW-1:0]         last_q, last_d;
  logic [NUM_PORTS-1:0]  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;
  logic [7:0]            rd_byte;
  logic [1:0]            sz;
  logic [MAXB-1:0][7:0]  full;
  logic                  ext;

  // A byte captured on the first stalled edge stands in for ram_in on resume.
  assign rd_byte = hold_vld_q ? hold_q : bus.ram_in;

  // Round-robin pick: first eligible port above last_q, else first from 0.
  always_comb begin
    eligible = bus.req_in & ~done_q;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (!gnt_vld && eligible[j] && (PW'(j) > last_q)) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (!gnt_vld && eligible[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  // Next-state: everything freezes while rdy_in is low except the hold byte.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    we_d       = we_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    last_d     = last_q;
    done_d     = done_q;
    rdata_d    = rdata_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sz         = '0;
    full       = rbuf_q;
    ext        = 1'b0;
    if (bus.rdy_in) begin
      done_d     = '0;
      hold_vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
              if (gnt_idx == PW'(j)) begin
                we_d    = bus.we_in[j];
                sgn_d   = bus.sgn_in[j];
                sz      = bus.size_in[2*j +: 2];
                addr_d  = bus.addr_in[ADDR_WIDTH*j +: ADDR_WIDTH];
                wdata_d = bus.wdata_in[DATA_WIDTH*j +: DATA_WIDTH];
              end
            end
            n_d     = ((4'd1 << sz) > 4'(MAXB)) ? 4'(MAXB) : (4'd1 << sz);
            cnt_d   = '0;
            last_d  = gnt_idx;
            state_d = S_XFER;
          end
        end
        S_XFER: begin
          if (!we_q) begin
            for (int unsigned b = 1; b < MAXB; b++) begin
              if (cnt_q == 3'(b)) rbuf_d[b-1] = rd_byte;
            end
          end
          if ({1'b0, cnt_q} == n_q - 4'd1) begin
            if (we_q) begin
              state_d = S_IDLE;
              for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (last_q == PW'(j)) done_d[j] = 1'b1;
              end
            end else begin
              state_d = S_TAIL;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_TAIL: begin
          for (int unsigned b = 0; b < MAXB; b++) begin
            if (n_q == 4'(b + 1)) full[b] = rd_byte;
          end
          ext = sgn_q & rd_byte[7];
          for (int unsigned b = 0; b < MAXB; b++) begin
            if (4'(b) >= n_q) full[b] = {8{ext}};
          end
          rdata_d = full;
          for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (last_q == PW'(j)) done_d[j] = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (!hold_vld_q) begin
      hold_d     = bus.ram_in;
      hold_vld_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      last_q     <= PW'(NUM_PORTS - 1);
      done_q     <= '0;
      rdata_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      we_q       <= we_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      last_q     <= last_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  // RAM port drive; write strobe forced low under reset or pause.
  always_comb begin
    bus.ram_rw_out   = 1'b0;
    bus.ram_addr_out = '0;
    bus.ram_data_out = '0;
    if (state_q == S_XFER) begin
      bus.ram_addr_out = addr_q + ADDR_WIDTH'(cnt_q);
      bus.ram_rw_out   = we_q;
      if (we_q) begin
        for (int unsigned b = 0; b < MAXB; b++) begin
          if (cnt_q == 3'(b)) bus.ram_data_out = wdata_q[b];
        end
      end
    end else if (state_q == S_TAIL) begin
      bus.ram_addr_out = addr_q + ADDR_WIDTH'(cnt_q);
    end
    if (rst_in || !bus.rdy_in) bus.ram_rw_out = 1'b0;
  end

  assign bus.done_out  = done_q;
  assign bus.rdata_out = rdata_q;
endmodule
